// File: rtl/mips_dmem_responder.sv
// Data-memory responder: target side of the MIPS32 core's load/store port.
// One word-aligned request at a time, WAIT_STATES wait cycles, byte-enabled RAM.
module mips_dmem_responder #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] MEM_BASE    = 32'h1001_0000
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy
);

    localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [32:0] SPAN     = 33'd1 << (ADDR_WIDTH + 2);
    localparam logic [3:0]  CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_error_q, rsp_error_d;
    logic        busy_q, busy_d;

    logic [31:0] ram [DEPTH];

    logic                  commit;
    logic                  cur_wr;
    logic [31:0]           cur_addr;
    logic [31:0]           cur_wdata;
    logic [3:0]            cur_be;
    logic [31:0]           cur_off;
    logic                  cur_err;
    logic [ADDR_WIDTH-1:0] cur_idx;

    // A zero-wait commit happens on the accept edge, so it must use the live request.
    always_comb begin
        cur_wr    = (state_q == S_IDLE) ? req_write : wr_q;
        cur_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
        cur_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
        cur_be    = (state_q == S_IDLE) ? req_be    : be_q;
        cur_off   = cur_addr - MEM_BASE;
        cur_err   = (cur_addr[1:0] != 2'b00) || (cur_addr < MEM_BASE) ||
                    ({1'b0, cur_off} >= SPAN);
        cur_idx   = cur_off[ADDR_WIDTH+1:2];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        commit      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (commit) begin
            rsp_error_d = cur_err;
            rsp_rdata_d = (cur_err || cur_wr) ? '0 : ram[cur_idx];
        end

        // The first RESP cycle is the RAM access cycle; rsp_valid rises one edge later.
        rsp_valid_d = (state_q == S_RESP) && !(rsp_valid_q && rsp_ready);
        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
            busy_q      <= busy_d;
        end
    end

    // RAM is never cleared; reset only blocks a commit that would coincide with it.
    always_ff @(posedge CLK) begin
        if (reset && commit && cur_wr && !cur_err) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (cur_be[k]) begin
                    ram[cur_idx][8*k +: 8] <= cur_wdata[8*k +: 8];
                end
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Bench for mips_dmem_responder: two instances (WAIT_STATES 0 and 1) checked
// against a word-array memory model, directed vectors and corner sequences.
module tb_mips_dmem_responder;

    localparam logic [31:0]   BASE  = 32'h1001_0000;
    localparam int unsigned   DEPTH = 256;

    logic        CLK = 1'b0;
    logic        rst_n     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_error [2];
    logic        busy      [2];

    always #5 CLK = ~CLK;

    mips_dmem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0), .MEM_BASE(BASE)) u_dut0 (
        .CLK(CLK), .reset(rst_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_error(rsp_error[0]), .busy(busy[0])
    );

    mips_dmem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(1), .MEM_BASE(BASE)) u_dut1 (
        .CLK(CLK), .reset(rst_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_error(rsp_error[1]), .busy(busy[1])
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] model [2][DEPTH];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_err(input logic [31:0] a);
        longint unsigned ua = a;
        return (ua % 4 != 0) || (ua < BASE) || (ua >= BASE + 4 * DEPTH);
    endfunction

    function automatic int ref_idx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    task automatic model_write(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be);
        logic [31:0] w;
        w = model[d][ref_idx(addr)];
        for (int k = 0; k < 4; k++)
            if (be[k]) w[8*k +: 8] = wdata[8*k +: 8];
        model[d][ref_idx(addr)] = w;
    endtask

    task automatic wait_rsp(input int d, output int lat);
        lat = 0;
        while (rsp_valid[d] !== 1'b1 && lat < 40) begin
            @(posedge CLK); #1;
            lat++;
        end
    endtask

    task automatic handshake(input int d);
        rsp_ready[d] = 1'b1;
        @(posedge CLK); #1;
        rsp_ready[d] = 1'b0;
        check("rsp_valid_drop", 32'(rsp_valid[d]), 0);
        check("req_ready_back", 32'(req_ready[d]), 1);
    endtask

    // Called one time unit after a rising edge with the DUT idle.
    task automatic txn(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] rdata, output logic err);
        int lat;
        check("req_ready_idle", 32'(req_ready[d]), 1);
        req_write[d] = wr;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        req_valid[d] = 1'b1;
        @(posedge CLK); #1;
        req_valid[d] = 1'b0;
        wait_rsp(d, lat);
        check("latency", lat, d + 1);
        rdata = rsp_rdata[d];
        err   = rsp_error[d];
        handshake(d);
    endtask

    task automatic op(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be);
        logic [31:0] r, exp_r;
        logic        e;
        bit          exp_e;
        exp_e = ref_err(addr);
        exp_r = (wr || exp_e) ? 32'h0 : model[d][ref_idx(addr)];
        txn(d, wr, addr, wdata, be, r, e);
        check("op_err", 32'(e), 32'(exp_e));
        check("op_rdata", r, exp_r);
        if (wr && !exp_e) model_write(d, addr, wdata, be);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] a;
        int          d;
        bit          wr;

        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_write[i] = 1'b0;
            req_addr[i] = '0; req_wdata[i] = '0; req_be[i] = '0; rsp_ready[i] = 1'b0;
        end
        repeat (2) @(posedge CLK);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("por_req_ready", 32'(req_ready[i]), 1);
            check("por_rsp_valid", 32'(rsp_valid[i]), 0);
            check("por_rsp_rdata", rsp_rdata[i], 0);
            check("por_rsp_error", 32'(rsp_error[i]), 0);
            check("por_busy", 32'(busy[i]), 0);
            rst_n[i] = 1'b1;
        end
        @(posedge CLK); #1;

        // Fill both memories so every later read has a known expected value.
        for (int i = 0; i < int'(DEPTH); i++)
            for (int k = 0; k < 2; k++)
                op(k, 1'b1, BASE + 32'(4 * i), $urandom, 4'hF);

        vecs.push_back('{1'b1, 32'h1001_0004, 32'hFFFF_FFFC, 4'hF, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 32'h1001_0004, 32'h0,         4'hF, 32'hFFFF_FFFC, 1'b0});
        vecs.push_back('{1'b1, 32'h1001_0008, 32'h0000_0000, 4'hF, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 32'h1001_0008, 32'hAABB_CCDD, 4'h5, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 32'h1001_0008, 32'h0,         4'h0, 32'h00BB_00DD, 1'b0});
        vecs.push_back('{1'b1, 32'h1001_0008, 32'h1234_5678, 4'h0, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 32'h1001_0008, 32'h0,         4'hF, 32'h00BB_00DD, 1'b0});
        vecs.push_back('{1'b0, 32'h1001_0002, 32'h0,         4'hF, 32'h0, 1'b1});
        vecs.push_back('{1'b1, 32'h1001_0000, 32'h0123_4567, 4'hF, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 32'h1001_0400, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 32'h1001_0000, 32'h0,         4'hF, 32'h0123_4567, 1'b0});
        vecs.push_back('{1'b1, 32'h1001_03FC, 32'h1111_2222, 4'hF, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 32'h1001_03FC, 32'h0,         4'hF, 32'h1111_2222, 1'b0});
        vecs.push_back('{1'b0, 32'h1001_0400, 32'h0,         4'hF, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 32'h1000_FFFC, 32'h0,         4'hF, 32'h0, 1'b1});
        vecs.push_back('{1'b1, 32'h1001_0006, 32'h5555_5555, 4'hF, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 32'h1001_0004, 32'h0,         4'hF, 32'hFFFF_FFFC, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            logic [31:0] r;
            logic        e;
            txn(1, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, r, e);
            check("vec_rdata", r, vecs[i].exp_rdata);
            check("vec_err", 32'(e), 32'(vecs[i].exp_err));
            if (vecs[i].wr && !vecs[i].exp_err)
                model_write(1, vecs[i].addr, vecs[i].wdata, vecs[i].be);
        end

        // Reset held with a pending write: nothing is accepted or committed.
        for (int k = 0; k < 2; k++) op(k, 1'b0, BASE + 32'd16, 32'h0, 4'hF);
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; req_valid[k] = 1'b1; req_write[k] = 1'b1;
            req_addr[k] = BASE + 32'd16; req_wdata[k] = 32'hBAD0_BAD0; req_be[k] = 4'hF;
        end
        repeat (2) begin
            @(posedge CLK); #1;
            for (int k = 0; k < 2; k++) begin
                check("rst_req_ready", 32'(req_ready[k]), 1);
                check("rst_rsp_valid", 32'(rsp_valid[k]), 0);
                check("rst_rsp_rdata", rsp_rdata[k], 0);
                check("rst_busy", 32'(busy[k]), 0);
            end
        end
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0;
            rst_n[k] = 1'b1;
        end
        @(posedge CLK); #1;
        for (int k = 0; k < 2; k++) op(k, 1'b0, BASE + 32'd16, 32'h0, 4'hF);

        // Backpressure, then a request presented on the handshake edge.
        for (int k = 0; k < 2; k++) begin
            logic [31:0] exp_r;
            op(k, 1'b1, BASE + 32'd48, 32'h1357_9BDF ^ 32'(k), 4'hF);
            exp_r = model[k][12];
            req_write[k] = 1'b0; req_addr[k] = BASE + 32'd48; req_be[k] = 4'hF;
            req_valid[k] = 1'b1;
            @(posedge CLK); #1;
            req_valid[k] = 1'b0;
            wait_rsp(k, lat);
            check("bp_latency", lat, k + 1);
            repeat (5) begin
                check("bp_rsp_valid", 32'(rsp_valid[k]), 1);
                check("bp_rsp_rdata", rsp_rdata[k], exp_r);
                check("bp_req_ready", 32'(req_ready[k]), 0);
                @(posedge CLK); #1;
            end
            req_addr[k] = BASE; req_valid[k] = 1'b1; rsp_ready[k] = 1'b1;
            @(posedge CLK); #1;
            rsp_ready[k] = 1'b0;
            check("bp_rel_rsp_valid", 32'(rsp_valid[k]), 0);
            check("bp_rel_req_ready", 32'(req_ready[k]), 1);
            check("bp_rel_busy", 32'(busy[k]), 0);
            @(posedge CLK); #1;
            req_valid[k] = 1'b0;
            check("bp_next_busy", 32'(busy[k]), 1);
            wait_rsp(k, lat);
            check("bp_next_latency", lat, k + 1);
            check("bp_next_rdata", rsp_rdata[k], model[k][0]);
            handshake(k);
        end

        // Reset during WAIT abandons the write.
        op(1, 1'b1, BASE + 32'd32, 32'h5A5A_5A5A, 4'hF);
        req_write[1] = 1'b1; req_addr[1] = BASE + 32'd32; req_wdata[1] = 32'h0000_0001;
        req_be[1] = 4'hF; req_valid[1] = 1'b1;
        @(posedge CLK); #1;
        req_valid[1] = 1'b0;
        check("mid_busy_wait", 32'(busy[1]), 1);
        rst_n[1] = 1'b0;
        #1;
        check("mid_busy_rst", 32'(busy[1]), 0);
        @(posedge CLK); #1;
        rst_n[1] = 1'b1;
        repeat (3) begin
            @(posedge CLK); #1;
            check("mid_no_rsp", 32'(rsp_valid[1]), 0);
        end
        op(1, 1'b0, BASE + 32'd32, 32'h0, 4'hF);

        repeat (300) begin
            d  = $urandom_range(0, 1);
            wr = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0: a = BASE + 32'($urandom_range(0, 1023));
                1: a = BASE + 32'd1024 + 32'(4 * $urandom_range(0, 15));
                2: a = BASE - 32'(4 * $urandom_range(1, 16));
                3: a = $urandom;
                default: a = BASE + 32'(4 * $urandom_range(0, 255));
            endcase
            op(d, wr, a, $urandom, 4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
